// File: rtl/dsp_file_pkg.sv
// Shared definitions for the DSP file controller: FSM encoding and address sizing.
package dsp_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } file_state_t;

    // Width of the file-index field of a RAM address; never zero.
    function automatic int file_bits(input int num_files);
        return (num_files > 1) ? $clog2(num_files) : 1;
    endfunction

    function automatic int ram_addr_bits(input int num_files, input int depth);
        return file_bits(num_files) + $clog2(depth);
    endfunction

endpackage

// File: rtl/dsp_file_controller_if.sv
// Equation-engine file handshake plus the host preload/drain port.
interface dsp_file_controller_if #(
    parameter int dw = 32
);
    logic [7:0]    file_num;
    logic          file_read;
    logic          file_write;
    logic [dw-1:0] file_write_data;
    logic [dw-1:0] file_read_data;
    logic          file_active;
    logic [31:0]   rd_ptr;
    logic [31:0]   wr_ptr;
    logic          host_req;
    logic          host_we;
    logic          host_clear;
    logic [7:0]    host_file;
    logic [dw-1:0] host_wdata;
    logic          host_ack;
    logic [dw-1:0] host_rdata;
    logic          file_error;

    modport master (
        output file_num, file_read, file_write, file_write_data,
        output host_req, host_we, host_clear, host_file, host_wdata,
        input  file_read_data, file_active, rd_ptr, wr_ptr,
        input  host_ack, host_rdata, file_error
    );

    modport slave (
        input  file_num, file_read, file_write, file_write_data,
        input  host_req, host_we, host_clear, host_file, host_wdata,
        output file_read_data, file_active, rd_ptr, wr_ptr,
        output host_ack, host_rdata, file_error
    );
endinterface

// File: rtl/dsp_file_ram.sv
// Simple dual-port RAM holding all files back to back; one-cycle registered read.
module dsp_file_ram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/dsp_file_controller.sv
// Circular-buffer file store shared by the equation engines and the host port.
// One access in flight at a time; equation requests win over host requests.
module dsp_file_controller
    import dsp_file_pkg::*;
#(
    parameter int dw        = 32,
    parameter int NUM_FILES = 4,
    parameter int DEPTH     = 256
) (
    input logic                 wb_clk,
    input logic                 wb_rst,
    dsp_file_controller_if.slave bus
);
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;
    localparam int FW       = file_bits(NUM_FILES);
    localparam int AW       = ram_addr_bits(NUM_FILES, DEPTH);
    localparam int NF_SLOTS = 1 << FW;

    file_state_t state_reg, state_next;

    logic [PW-1:0] rptr_arr [NF_SLOTS];
    logic [PW-1:0] wptr_arr [NF_SLOTS];
    logic [CW-1:0] cnt_arr  [NF_SLOTS];
    logic [NF_SLOTS-1:0] empty_vec, full_vec;

    // Captured operation
    logic          src_host_reg, op_write_reg, op_clear_reg, op_ok_reg, op_err_reg;
    logic [FW-1:0] file_reg;
    logic [PW-1:0] ptr_reg;
    logic [dw-1:0] wdata_reg;

    // Host request parked while the equation side owns the FSM
    logic          hpend_valid_reg, hpend_we_reg, hpend_clear_reg;
    logic [7:0]    hpend_file_reg;
    logic [dw-1:0] hpend_wdata_reg;

    logic          ram_we_reg;
    logic [AW-1:0] ram_addr_reg;
    logic [dw-1:0] ram_wdata_reg, ram_rdata;
    logic          commit_reg;

    logic          file_active_reg, host_ack_reg, file_error_reg;
    logic [dw-1:0] file_read_data_reg, host_rdata_reg;
    logic [31:0]   rd_ptr_reg, wr_ptr_reg;

    for (genvar gi = 0; gi < NF_SLOTS; gi++) begin : g_flags
        assign empty_vec[gi] = (cnt_arr[gi] == '0);
        assign full_vec[gi]  = (cnt_arr[gi] == CW'(DEPTH));
    end

    logic          eq_req, h_valid, h_we, h_clear;
    logic [7:0]    h_file;
    logic [dw-1:0] h_wdata;
    logic          start, take_host;

    assign eq_req    = bus.file_read | bus.file_write;
    assign h_valid   = bus.host_req | hpend_valid_reg;
    assign h_we      = bus.host_req ? bus.host_we    : hpend_we_reg;
    assign h_clear   = bus.host_req ? bus.host_clear : hpend_clear_reg;
    assign h_file    = bus.host_req ? bus.host_file  : hpend_file_reg;
    assign h_wdata   = bus.host_req ? bus.host_wdata : hpend_wdata_reg;
    assign start     = (state_reg == ST_IDLE) && (eq_req || h_valid);
    assign take_host = (state_reg == ST_IDLE) && !eq_req && h_valid;

    logic [7:0]    req_file;
    logic [FW-1:0] req_idx;
    logic          req_write, req_clear, req_in_range, req_ok, req_err;

    // Accept/reject is decided at capture; nothing else touches pointers meanwhile.
    always_comb begin
        req_file     = eq_req ? bus.file_num : h_file;
        req_write    = eq_req ? bus.file_write : h_we;
        req_clear    = !eq_req && h_clear;
        req_in_range = ({1'b0, req_file} < 9'(NUM_FILES));
        req_idx      = req_file[FW-1:0];
        req_ok       = req_in_range &&
                       (req_clear || (req_write ? !full_vec[req_idx] : !empty_vec[req_idx]));
        req_err      = !req_in_range ||
                       (!req_clear && (req_write ? full_vec[req_idx] : empty_vec[req_idx])) ||
                       (bus.file_read && bus.file_write);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (eq_req || h_valid) state_next = ST_ACCESS;
            ST_ACCESS:  state_next = ST_DATA;
            ST_DATA:    state_next = ST_RELEASE;
            ST_RELEASE: if (src_host_reg || !eq_req) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    logic          sel_in_range;
    logic [FW-1:0] sel_idx;
    assign sel_in_range = ({1'b0, bus.file_num} < 9'(NUM_FILES));
    assign sel_idx      = bus.file_num[FW-1:0];

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_reg          <= ST_IDLE;
            src_host_reg       <= 1'b0;
            op_write_reg       <= 1'b0;
            op_clear_reg       <= 1'b0;
            op_ok_reg          <= 1'b0;
            op_err_reg         <= 1'b0;
            file_reg           <= '0;
            ptr_reg            <= '0;
            wdata_reg          <= '0;
            hpend_valid_reg    <= 1'b0;
            hpend_we_reg       <= 1'b0;
            hpend_clear_reg    <= 1'b0;
            hpend_file_reg     <= '0;
            hpend_wdata_reg    <= '0;
            ram_we_reg         <= 1'b0;
            ram_addr_reg       <= '0;
            ram_wdata_reg      <= '0;
            commit_reg         <= 1'b0;
            file_active_reg    <= 1'b0;
            host_ack_reg       <= 1'b0;
            file_error_reg     <= 1'b0;
            file_read_data_reg <= '0;
            host_rdata_reg     <= '0;
            rd_ptr_reg         <= '0;
            wr_ptr_reg         <= '0;
            for (int i = 0; i < NF_SLOTS; i++) begin
                rptr_arr[i] <= '0;
                wptr_arr[i] <= '0;
                cnt_arr[i]  <= '0;
            end
        end else begin
            state_reg <= state_next;

            if (start) begin
                src_host_reg <= take_host;
                op_write_reg <= req_write;
                op_clear_reg <= req_clear;
                op_ok_reg    <= req_ok;
                op_err_reg   <= req_err;
                file_reg     <= req_idx;
                ptr_reg      <= req_write ? wptr_arr[req_idx] : rptr_arr[req_idx];
                wdata_reg    <= eq_req ? bus.file_write_data : h_wdata;
            end

            if (take_host) begin
                hpend_valid_reg <= 1'b0;
            end else if (bus.host_req) begin
                hpend_valid_reg <= 1'b1;
                hpend_we_reg    <= bus.host_we;
                hpend_clear_reg <= bus.host_clear;
                hpend_file_reg  <= bus.host_file;
                hpend_wdata_reg <= bus.host_wdata;
            end

            // RAM command leaves ACCESS registered; the RAM acts on the DATA edge.
            ram_we_reg    <= (state_reg == ST_ACCESS) && op_ok_reg && op_write_reg && !op_clear_reg;
            ram_addr_reg  <= {file_reg, ptr_reg};
            ram_wdata_reg <= wdata_reg;
            commit_reg    <= (state_reg == ST_DATA);

            file_active_reg <= !src_host_reg && ((state_reg == ST_ACCESS) || (state_reg == ST_DATA));
            host_ack_reg    <= commit_reg && src_host_reg;
            file_error_reg  <= commit_reg && op_err_reg;

            if (commit_reg) begin
                if (!src_host_reg && !op_write_reg) begin
                    file_read_data_reg <= op_ok_reg ? ram_rdata : '0;
                end
                if (src_host_reg && !op_write_reg && !op_clear_reg) begin
                    host_rdata_reg <= op_ok_reg ? ram_rdata : '0;
                end
                if (op_clear_reg) begin
                    if (op_ok_reg) begin
                        rptr_arr[file_reg] <= '0;
                        wptr_arr[file_reg] <= '0;
                        cnt_arr[file_reg]  <= '0;
                    end
                end else if (op_ok_reg) begin
                    if (op_write_reg) begin
                        wptr_arr[file_reg] <= wptr_arr[file_reg] + PW'(1);
                        cnt_arr[file_reg]  <= cnt_arr[file_reg] + CW'(1);
                    end else begin
                        rptr_arr[file_reg] <= rptr_arr[file_reg] + PW'(1);
                        cnt_arr[file_reg]  <= cnt_arr[file_reg] - CW'(1);
                    end
                end
            end

            rd_ptr_reg <= sel_in_range ? 32'(rptr_arr[sel_idx]) : '0;
            wr_ptr_reg <= sel_in_range ? 32'(wptr_arr[sel_idx]) : '0;
        end
    end

    dsp_file_ram #(
        .DW (dw),
        .AW (AW)
    ) u_ram (
        .clk     (wb_clk),
        .wr_en   (ram_we_reg),
        .wr_addr (ram_addr_reg),
        .wr_data (ram_wdata_reg),
        .rd_addr (ram_addr_reg),
        .rd_data (ram_rdata)
    );

    assign bus.file_active    = file_active_reg;
    assign bus.file_read_data = file_read_data_reg;
    assign bus.host_ack       = host_ack_reg;
    assign bus.host_rdata     = host_rdata_reg;
    assign bus.file_error     = file_error_reg;
    assign bus.rd_ptr         = rd_ptr_reg;
    assign bus.wr_ptr         = wr_ptr_reg;
endmodule

// File: tb/tb_dsp_file_controller.sv
// Directed bench for dsp_file_controller: hand-computed expectations per transaction.
module tb_dsp_file_controller;
    localparam int DEPTH = 256;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;
    int   n_chk  = 0;
    int   n_err  = 0;

    always #5 wb_clk = ~wb_clk;

    dsp_file_controller_if #(.dw(32)) bus ();

    dsp_file_controller #(
        .dw        (32),
        .NUM_FILES (4),
        .DEPTH     (DEPTH)
    ) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Equation-side access: request sampled at edge t, released after edge t+3.
    task automatic eq_access(input string tag, input logic wr, input logic rd,
                             input logic [7:0] f, input logic [31:0] wd,
                             input logic exp_err, input logic chk_data,
                             input logic [31:0] exp_data);
        bus.file_num        = f;
        bus.file_write      = wr;
        bus.file_read       = rd;
        bus.file_write_data = wd;
        tick();
        tick();
        check_val({tag, ".act1"}, 32'(bus.file_active), 32'd1);
        tick();
        check_val({tag, ".act2"}, 32'(bus.file_active), 32'd1);
        tick();
        check_val({tag, ".act3"}, 32'(bus.file_active), 32'd0);
        check_val({tag, ".err"}, 32'(bus.file_error), 32'(exp_err));
        if (chk_data) check_val({tag, ".data"}, bus.file_read_data, exp_data);
        bus.file_write = 1'b0;
        bus.file_read  = 1'b0;
        tick();
        $display("eq %s f=%0d wr=%0b rd=%0b wdata=0x%0h rdata=0x%0h rd_ptr=%0d wr_ptr=%0d",
                 tag, f, wr, rd, wd, bus.file_read_data, bus.rd_ptr, bus.wr_ptr);
    endtask

    // Host access: one-cycle request at edge t, ack pulse after edge t+3.
    task automatic host_access(input string tag, input logic we, input logic clr,
                               input logic [7:0] f, input logic [31:0] wd,
                               input logic exp_err, input logic chk_data,
                               input logic [31:0] exp_data);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_clear = clr;
        bus.host_file  = f;
        bus.host_wdata = wd;
        tick();
        bus.host_req = 1'b0;
        tick();
        tick();
        tick();
        check_val({tag, ".ack"}, 32'(bus.host_ack), 32'd1);
        check_val({tag, ".err"}, 32'(bus.file_error), 32'(exp_err));
        if (chk_data) check_val({tag, ".rdata"}, bus.host_rdata, exp_data);
        tick();
        check_val({tag, ".ack_off"}, 32'(bus.host_ack), 32'd0);
        $display("host %s f=%0d we=%0b clr=%0b wdata=0x%0h rdata=0x%0h",
                 tag, f, we, clr, wd, bus.host_rdata);
    endtask

    initial begin
        int act_cnt;
        int ack_at;
        logic ack_err;

        bus.file_num = '0; bus.file_read = 1'b0; bus.file_write = 1'b0; bus.file_write_data = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_clear = 1'b0;
        bus.host_file = '0; bus.host_wdata = '0;

        repeat (3) tick();
        check_val("rst.active", 32'(bus.file_active), 32'd0);
        check_val("rst.ack", 32'(bus.host_ack), 32'd0);
        check_val("rst.err", 32'(bus.file_error), 32'd0);
        check_val("rst.rdata", bus.file_read_data, 32'd0);
        check_val("rst.hrdata", bus.host_rdata, 32'd0);
        check_val("rst.rd_ptr", bus.rd_ptr, 32'd0);
        check_val("rst.wr_ptr", bus.wr_ptr, 32'd0);
        wb_rst = 1'b0;
        tick();

        // Host preload of file 1, then in-order equation reads
        host_access("h1w0", 1'b1, 1'b0, 8'd1, 32'h11, 1'b0, 1'b0, 32'h0);
        host_access("h1w1", 1'b1, 1'b0, 8'd1, 32'h22, 1'b0, 1'b0, 32'h0);
        host_access("h1w2", 1'b1, 1'b0, 8'd1, 32'h33, 1'b0, 1'b0, 32'h0);
        bus.file_num = 8'd1;
        tick(); tick();
        check_val("pre.wr_ptr", bus.wr_ptr, 32'd3);
        check_val("pre.rd_ptr", bus.rd_ptr, 32'd0);
        eq_access("r1a", 1'b0, 1'b1, 8'd1, 32'h0, 1'b0, 1'b1, 32'h11);
        check_val("r1a.rd_ptr", bus.rd_ptr, 32'd1);
        eq_access("r1b", 1'b0, 1'b1, 8'd1, 32'h0, 1'b0, 1'b1, 32'h22);
        check_val("r1b.rd_ptr", bus.rd_ptr, 32'd2);
        eq_access("r1c", 1'b0, 1'b1, 8'd1, 32'h0, 1'b0, 1'b1, 32'h33);
        check_val("r1c.rd_ptr", bus.rd_ptr, 32'd3);
        check_val("r1c.wr_ptr", bus.wr_ptr, 32'd3);

        // Read held for 10 cycles is serviced once
        host_access("h3w", 1'b1, 1'b0, 8'd3, 32'h44, 1'b0, 1'b0, 32'h0);
        bus.file_num = 8'd3;
        bus.file_read = 1'b1;
        act_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.file_active) act_cnt++;
        end
        bus.file_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.file_active) act_cnt++;
        end
        check_val("hold.active_cycles", 32'(act_cnt), 32'd2);
        check_val("hold.data", bus.file_read_data, 32'h44);
        check_val("hold.rd_ptr", bus.rd_ptr, 32'd1);
        $display("eq hold f=3 active_cycles=%0d rdata=0x%0h rd_ptr=%0d", act_cnt, bus.file_read_data, bus.rd_ptr);

        // Fill file 0, overflow, then confirm the dropped word and the free slot
        for (int i = 0; i < DEPTH; i++) begin
            eq_access("fill", 1'b1, 1'b0, 8'd0, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0);
        end
        check_val("fill.wr_ptr", bus.wr_ptr, 32'd0);
        check_val("fill.rd_ptr", bus.rd_ptr, 32'd0);
        eq_access("ovf", 1'b1, 1'b0, 8'd0, 32'hDEAD, 1'b1, 1'b0, 32'h0);
        check_val("ovf.wr_ptr", bus.wr_ptr, 32'd0);
        eq_access("r0", 1'b0, 1'b1, 8'd0, 32'h0, 1'b0, 1'b1, 32'h100);
        check_val("r0.rd_ptr", bus.rd_ptr, 32'd1);
        eq_access("w0", 1'b1, 1'b0, 8'd0, 32'hBEEF, 1'b0, 1'b0, 32'h0);
        check_val("w0.wr_ptr", bus.wr_ptr, 32'd1);

        // Empty read
        eq_access("r2e", 1'b0, 1'b1, 8'd2, 32'h0, 1'b1, 1'b1, 32'h0);
        check_val("r2e.rd_ptr", bus.rd_ptr, 32'd0);

        // Equation write and host write collide; host waits for release
        bus.file_num = 8'd2; bus.file_write = 1'b1; bus.file_write_data = 32'h55;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_clear = 1'b0;
        bus.host_file = 8'd3; bus.host_wdata = 32'h66;
        tick();
        bus.host_req = 1'b0;
        tick();
        check_val("col.act1", 32'(bus.file_active), 32'd1);
        tick();
        check_val("col.act2", 32'(bus.file_active), 32'd1);
        tick();
        check_val("col.act3", 32'(bus.file_active), 32'd0);
        check_val("col.ack_early", 32'(bus.host_ack), 32'd0);
        tick();
        check_val("col.ack_release", 32'(bus.host_ack), 32'd0);
        check_val("col.wr_ptr", bus.wr_ptr, 32'd1);
        bus.file_write = 1'b0;
        ack_at = -1;
        ack_err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.host_ack && ack_at < 0) begin
                ack_at = i;
                ack_err = bus.file_error;
            end
        end
        check_val("col.ack_cycle", 32'(ack_at), 32'd5);
        check_val("col.ack_err", 32'(ack_err), 32'd0);
        $display("eq+host collide eq_f=2 host_f=3 host_ack_cycle=%0d", ack_at);
        host_access("h3r", 1'b0, 1'b0, 8'd3, 32'h0, 1'b0, 1'b1, 32'h66);

        // Out-of-range selections
        eq_access("w5", 1'b1, 1'b0, 8'd5, 32'h5A, 1'b1, 1'b0, 32'h0);
        check_val("w5.wr_ptr", bus.wr_ptr, 32'd0);
        host_access("h9r", 1'b0, 1'b0, 8'd9, 32'h0, 1'b1, 1'b1, 32'h0);

        // Read and write together: performed as a write, flagged
        eq_access("rw2", 1'b1, 1'b1, 8'd2, 32'h77, 1'b1, 1'b0, 32'h0);
        check_val("rw2.wr_ptr", bus.wr_ptr, 32'd2);
        eq_access("r2", 1'b0, 1'b1, 8'd2, 32'h0, 1'b0, 1'b1, 32'h55);

        // Host clear of file 0
        bus.file_num = 8'd0;
        tick(); tick();
        check_val("clr.pre_rd", bus.rd_ptr, 32'd1);
        check_val("clr.pre_wr", bus.wr_ptr, 32'd1);
        host_access("h0clr", 1'b0, 1'b1, 8'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_val("clr.rd_ptr", bus.rd_ptr, 32'd0);
        check_val("clr.wr_ptr", bus.wr_ptr, 32'd0);
        eq_access("r0c", 1'b0, 1'b1, 8'd0, 32'h0, 1'b1, 1'b1, 32'h0);

        // Reset during DATA of a write
        bus.file_num = 8'd2; bus.file_write = 1'b1; bus.file_write_data = 32'h99;
        tick();
        tick();
        check_val("rstmid.act_data", 32'(bus.file_active), 32'd1);
        wb_rst = 1'b1;
        bus.file_write = 1'b0;
        tick();
        check_val("rstmid.active", 32'(bus.file_active), 32'd0);
        check_val("rstmid.err", 32'(bus.file_error), 32'd0);
        wb_rst = 1'b0;
        tick();
        check_val("rstmid.active2", 32'(bus.file_active), 32'd0);
        tick();
        check_val("rstmid.rd_ptr2", bus.rd_ptr, 32'd0);
        check_val("rstmid.wr_ptr2", bus.wr_ptr, 32'd0);
        bus.file_num = 8'd1;
        tick(); tick();
        check_val("rstmid.wr_ptr1", bus.wr_ptr, 32'd0);
        $display("reset mid-write f=2 rd_ptr=%0d wr_ptr(f1)=%0d", bus.rd_ptr, bus.wr_ptr);
        eq_access("w1post", 1'b1, 1'b0, 8'd1, 32'hAB, 1'b0, 1'b0, 32'h0);
        check_val("w1post.wr_ptr", bus.wr_ptr, 32'd1);
        eq_access("r1post", 1'b0, 1'b1, 8'd1, 32'h0, 1'b0, 1'b1, 32'hAB);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dsp_file_controller.md
# dsp_file_controller

Storage and pointer manager for the DSP sample files consumed and produced by the DSP equation engines. Holds `NUM_FILES` circular word buffers in one shared RAM. Serves single-word read/write requests on the equation-side file handshake (`file_num` / `file_read` / `file_write` / `file_active`) and reports the selected file's read and write pointers. A lower-priority host port lets the Wishbone slave preload, drain and clear files.

## Interface
- `dw`, default 32: data word width.
- `NUM_FILES`, default 4: number of files; a power of two, ≤ 256.
- `DEPTH`, default 256: words per file; a power of two, ≥ 4.
- `wb_clk  in  1`: clock; the block's only clock.
- `wb_rst  in  1`: reset, synchronous and active-high.
- `file_num  in  8`: file select from the equation engine.
- `file_read`, `file_write`  in  1: level requests from the equation engine.
- `file_write_data  in  dw`: write word from the equation engine.
- `file_read_data  out  dw`: read word returned to the equation engine.
- `file_active  out  1`: busy/valid handshake to the equation engine.
- `rd_ptr`, `wr_ptr`  out  32: pointers of the file selected by `file_num`, zero-extended.
- `host_req  in  1`, `host_we  in  1`, `host_clear  in  1`, `host_file  in  8`, `host_wdata  in  dw`: host single-word access.
- `host_ack  out  1`, `host_rdata  out  dw`: host completion and read data.
- `file_error  out  1`: one-cycle pulse on any rejected access.

## Operation
- Per-file state: `rptr`, `wptr` (log2(DEPTH) bits) and `count` (log2(DEPTH)+1 bits). Empty is `count==0`; full is `count==DEPTH`. Pointers wrap from DEPTH-1 to 0.
- RAM address is {file, ptr}. RAM size is NUM_FILES×DEPTH words.
- FSM states:
  - IDLE: checks requests in fixed priority: `file_write`, then `file_read`, then `host_req`. Captures file, direction and data, then moves to ACCESS.
  - ACCESS: issues the RAM read or write, then moves to DATA.
  - DATA: registers read data and updates the pointer and count, then moves to RELEASE.
  - RELEASE: returns to IDLE once the originating request is low. Host requests are one-cycle, so they are always released immediately.
- `file_active` is 1 in ACCESS and DATA only, and only for equation-side requests.
- `file_read` and `file_write` both high: the access is a write. `file_error` pulses.
- Read of an empty file: no pointer change, the data register is loaded with 0, `file_error` pulses. The handshake still completes normally.
- Write to a full file: the data is dropped, no pointer change, `file_error` pulses.
- `file_num` or `host_file` ≥ NUM_FILES: no RAM access and no state change, `file_error` pulses. The handshake still completes normally.
- `host_clear` with `host_req`: sets `rptr`, `wptr` and `count` of `host_file` to 0. No RAM access. `host_ack` is returned.
- `rd_ptr` and `wr_ptr` are registered every cycle from the pointers of `file_num`. An out-of-range `file_num` reports 0 on both.

## Timing
- Reset values: `file_active`, `host_ack` and `file_error` are 0. `file_read_data`, `host_rdata`, `rd_ptr` and `wr_ptr` are 0. All pointers and counts are 0. FSM is in IDLE. RAM contents are unspecified.
- Reset applied mid-operation returns the FSM to IDLE on the next edge and abandons any in-flight access. Pointers reset.
- Equation-side request sampled high in IDLE at edge t:
  - `file_active` is 1 after edges t+1 and t+2, and 0 after edge t+3.
  - `file_read_data` is valid from edge t+3 and held until the next read completes.
  - The pointer and count update is visible on `rd_ptr`/`wr_ptr` after edge t+4.
- Host access sampled at edge t: `host_ack` is a one-cycle pulse after edge t+3, with `host_rdata` valid in the same cycle.
- `file_error` pulses in the same cycle `file_active` falls (equation side) or `host_ack` rises (host side).
- A request still high in RELEASE is not re-serviced. The requester must drop the request and re-raise it.
- Throughput: at most one access every 4 cycles.

## Structure
- Shared package `dsp_file_pkg`: state encodings (IDLE=0, ACCESS=1, DATA=2, RELEASE=3) and the address-width helper constant.
- Sub-module `dsp_file_ram`: simple dual-port synchronous RAM, dw×(NUM_FILES·DEPTH), with a 1-cycle registered read.
- Pointer and count arrays and the FSM live in the top module.

## Test plan
- Host writes 0x11, 0x22, 0x33 to file 1, then the equation side reads file 1 three times: reads return 0x11, 0x22, 0x33 in order; `rd_ptr` goes 1, 2, 3; after the third read `rd_ptr==wr_ptr==3`.
- Equation side holds `file_read` high for 10 cycles: exactly one access occurs; `file_active` is high for exactly 2 cycles.
- Fill file 0 with DEPTH writes, then one more write: the extra write raises `file_error`; `count` stays at DEPTH; `wr_ptr` wraps to 0.
- Read of empty file 2: `file_read_data==0`, `file_error` pulses, `rd_ptr` stays 0.
- `file_write` and `host_req` raised in the same cycle: the equation write completes first; `host_ack` arrives after the equation write's RELEASE; `file_num=5` is rejected with `file_error`.
- Reset asserted during DATA of a write: next cycle state is IDLE, `file_active` is 0, all pointers are 0.
